// File: rtl/controle_enchimento_caixa.sv
// Tank fill controller: debounces the High/Medium/Low probes, decodes a 2-bit level,
// drives the inlet valve with hysteresis and latches a fault on inconsistent probes
// or an overlong fill.
module controle_enchimento_caixa #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned FILL_TIMEOUT    = 1000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       High,
   input  logic       Medium,
   input  logic       Low,
   input  logic       ClearFault,
   output logic       ValvulaEntrada,
   output logic       Erro,
   output logic       Alarme,
   output logic [1:0] Nivel
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TmrW = $clog2(FILL_TIMEOUT + 1);
   localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] InitLast = CntW'(DEBOUNCE_CYCLES);
   localparam logic [TmrW-1:0] TmrMax   = TmrW'(FILL_TIMEOUT);
   localparam logic [TmrW-1:0] TmrLast  = TmrW'(FILL_TIMEOUT - 1);

   typedef enum logic [1:0] {StInit, StIdle, StFill, StFault} state_e;

   state_e          state_q, state_d;
   logic [2:0]      raw, stable_q, stable_d;
   logic [CntW-1:0] cnt_q [3];
   logic [CntW-1:0] cnt_d [3];
   logic [CntW-1:0] init_q, init_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [1:0]      level, nivel_d;
   logic            consistent, timeout;

   // Bit 2 = High, bit 1 = Medium, bit 0 = Low
   assign raw = {High, Medium, Low};

   // The timer value after this edge would reach the limit
   assign timeout = (timer_q >= TmrLast);

   // Per-probe debounce; during INIT the stable value tracks the raw probe directly
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '{default: '0};
      for (int i = 0; i < 3; i++) begin
         if (state_q == StInit) begin
            stable_d[i] = raw[i];
         end else if (raw[i] != stable_q[i]) begin
            if (cnt_q[i] == DebLast) begin
               stable_d[i] = raw[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   // Decode the debounced probes; only contiguous-from-bottom patterns are valid
   always_comb begin
      consistent = 1'b1;
      level      = 2'd0;
      unique case (stable_q)
         3'b000:  level = 2'd0;
         3'b001:  level = 2'd1;
         3'b011:  level = 2'd2;
         3'b111:  level = 2'd3;
         default: consistent = 1'b0;
      endcase
   end

   // Next-state logic; in FILL a full tank takes priority over the timeout
   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      timer_d = timer_q;
      unique case (state_q)
         StInit: begin
            if (init_q == InitLast) begin
               state_d = StIdle;
            end else begin
               init_d = init_q + CntW'(1);
            end
         end
         StIdle: begin
            if (!consistent) begin
               state_d = StFault;
            end else if (level <= 2'd1) begin
               state_d = StFill;
               timer_d = '0;
            end
         end
         StFill: begin
            timer_d = timeout ? TmrMax : timer_q + TmrW'(1);
            if (consistent && level == 2'd3) begin
               state_d = StIdle;
            end else if (!consistent || timeout) begin
               state_d = StFault;
            end
         end
         StFault: begin
            if (ClearFault && consistent) begin
               state_d = StIdle;
            end
         end
      endcase
      // Nivel stays at its reset value through INIT and holds across inconsistent probes
      nivel_d = (state_d != StInit && consistent) ? level : Nivel;
   end

   // State, debounce, timer and registered outputs loaded from next-state
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q        <= StInit;
         stable_q       <= 3'b000;
         cnt_q          <= '{default: '0};
         init_q         <= '0;
         timer_q        <= '0;
         ValvulaEntrada <= 1'b0;
         Erro           <= 1'b0;
         Alarme         <= 1'b0;
         Nivel          <= 2'd0;
      end else begin
         state_q        <= state_d;
         stable_q       <= stable_d;
         cnt_q          <= cnt_d;
         init_q         <= init_d;
         timer_q        <= timer_d;
         ValvulaEntrada <= (state_d == StFill);
         Erro           <= (state_d == StFault);
         Alarme         <= (state_d == StFault) || (state_d != StInit && nivel_d == 2'd0);
         Nivel          <= nivel_d;
      end
   end

endmodule

// File: tb/tb_controle_enchimento_caixa.sv
// Bench for controle_enchimento_caixa: directed vector table, hand-timed corner
// sequences and a randomized run checked against a behavioural reference model.
module tb_controle_enchimento_caixa;

   localparam int unsigned DEB = 4;
   localparam int unsigned TMO = 20;
   localparam int MInit = 0, MIdle = 1, MFill = 2, MFault = 3;

   logic       Clock, Reset, High, Medium, Low, ClearFault;
   logic       ValvulaEntrada, Erro, Alarme;
   logic [1:0] Nivel;

   int n_checks = 0;
   int n_err    = 0;
   bit model_en = 1'b0;

   typedef struct {
      bit         rst;
      logic [2:0] probes;
      bit         clr;
      int         cycles;
      bit         valve;
      bit         erro;
      bit         alarme;
      int         nivel;
   } vec_t;

   controle_enchimento_caixa #(
      .DEBOUNCE_CYCLES(DEB),
      .FILL_TIMEOUT   (TMO)
   ) dut (
      .Clock         (Clock),
      .Reset         (Reset),
      .High          (High),
      .Medium        (Medium),
      .Low           (Low),
      .ClearFault    (ClearFault),
      .ValvulaEntrada(ValvulaEntrada),
      .Erro          (Erro),
      .Alarme        (Alarme),
      .Nivel         (Nivel)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit rst, input logic [2:0] p, input bit clr);
      Reset = rst;
      {High, Medium, Low} = p;
      ClearFault = clr;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic expect_out(input string tag, input bit va, input bit er, input bit al,
                             input int nv);
      check({tag, " valve"}, 32'(ValvulaEntrada), 32'(va));
      check({tag, " erro"}, 32'(Erro), 32'(er));
      check({tag, " alarme"}, 32'(Alarme), 32'(al));
      check({tag, " nivel"}, 32'(Nivel), 32'(nv));
   endtask

   function automatic vec_t v(input bit rst, input logic [2:0] p, input bit clr, input int cyc,
                              input bit va, input bit er, input bit al, input int nv);
      vec_t r;
      r.rst = rst; r.probes = p; r.clr = clr; r.cycles = cyc;
      r.valve = va; r.erro = er; r.alarme = al; r.nivel = nv;
      return r;
   endfunction

   // Reference model: level = number of wet probes, valid only when they are wet from
   // the bottom up; each probe flips after DEB consecutive disagreeing samples.
   int         m_mode = MInit;
   int         m_init_edges = 0;
   int         m_open = 0;
   int         m_nivel = 0;
   logic [2:0] m_stab = 3'b000;
   int         m_run [3] = '{0, 0, 0};
   bit         e_valve = 0, e_erro = 0, e_alarme = 0;

   always @(posedge Clock) begin : ref_model
      logic [2:0] rawp;
      int         n;
      int         old_mode;
      bit         cons;
      rawp = {High, Medium, Low};
      if (Reset) begin
         m_mode = MInit; m_init_edges = 0; m_open = 0; m_nivel = 0; m_stab = 3'b000;
         for (int i = 0; i < 3; i++) m_run[i] = 0;
      end else begin
         n        = $countones(m_stab);
         cons     = (m_stab == 3'((1 << n) - 1));
         old_mode = m_mode;
         case (m_mode)
            MInit: begin
               m_init_edges++;
               if (m_init_edges == DEB + 1) m_mode = MIdle;
            end
            MIdle: begin
               if (!cons) m_mode = MFault;
               else if (n <= 1) begin m_mode = MFill; m_open = 0; end
            end
            MFill: begin
               m_open++;
               if (cons && n == 3) m_mode = MIdle;
               else if (!cons) m_mode = MFault;
               else if (m_open >= TMO) m_mode = MFault;
            end
            default: if (ClearFault && cons) m_mode = MIdle;
         endcase
         for (int i = 0; i < 3; i++) begin
            if (old_mode == MInit) begin
               m_stab[i] = rawp[i];
               m_run[i]  = 0;
            end else if (rawp[i] != m_stab[i]) begin
               m_run[i]++;
               if (m_run[i] == DEB) begin m_stab[i] = rawp[i]; m_run[i] = 0; end
            end else begin
               m_run[i] = 0;
            end
         end
         if (m_mode != MInit && cons) m_nivel = n;
      end
      e_valve  = (m_mode == MFill);
      e_erro   = (m_mode == MFault);
      e_alarme = (m_mode == MFault) || (m_mode != MInit && m_nivel == 0);
   end

   // Compare against the model mid-cycle on every cycle once reset has been applied
   always @(negedge Clock) begin
      if (model_en) begin
         check("model valve", 32'(ValvulaEntrada), 32'(e_valve));
         check("model erro", 32'(Erro), 32'(e_erro));
         check("model alarme", 32'(Alarme), 32'(e_alarme));
         check("model nivel", 32'(Nivel), 32'(m_nivel));
      end
   end

   initial begin
      vec_t       vq[$];
      logic [2:0] pattern, gmask;
      int         glitch_left;

      drive(1'b1, 3'b111, 1'b0);
      tick(1);
      model_en = 1'b1;

      // rst, probes, clr, cycles, valve, erro, alarme, nivel
      vq.push_back(v(1, 3'b111, 0, 1, 0, 0, 0, 0));   // reset held 2 edges
      vq.push_back(v(0, 3'b111, 0, 4, 0, 0, 0, 0));   // INIT keeps reset outputs
      vq.push_back(v(0, 3'b111, 0, 1, 0, 0, 0, 3));   // IDLE, full
      vq.push_back(v(0, 3'b111, 0, 3, 0, 0, 0, 3));
      vq.push_back(v(0, 3'b001, 0, 4, 0, 0, 0, 3));   // stable flipped, FSM not yet
      vq.push_back(v(0, 3'b001, 0, 1, 1, 0, 0, 1));   // valve opens on 5th edge
      vq.push_back(v(0, 3'b011, 0, 5, 1, 0, 0, 2));   // hysteresis band keeps filling
      vq.push_back(v(0, 3'b111, 0, 4, 1, 0, 0, 2));
      vq.push_back(v(0, 3'b111, 0, 1, 0, 0, 0, 3));   // full closes valve
      vq.push_back(v(0, 3'b101, 0, 3, 0, 0, 0, 3));   // 3-cycle glitch rejected
      vq.push_back(v(0, 3'b111, 0, 6, 0, 0, 0, 3));
      vq.push_back(v(0, 3'b101, 0, 4, 0, 0, 0, 3));   // 4-cycle pulse accepted
      vq.push_back(v(0, 3'b111, 0, 1, 0, 1, 1, 3));   // fault 5 edges after pulse start
      vq.push_back(v(0, 3'b111, 0, 2, 0, 1, 1, 3));
      vq.push_back(v(0, 3'b111, 1, 1, 0, 1, 1, 3));   // clear ignored: still inconsistent
      vq.push_back(v(0, 3'b111, 1, 1, 0, 0, 0, 3));   // clear accepted, held high
      vq.push_back(v(0, 3'b111, 0, 2, 0, 0, 0, 3));
      vq.push_back(v(0, 3'b101, 0, 5, 0, 1, 1, 3));   // inconsistent probes
      vq.push_back(v(0, 3'b101, 1, 3, 0, 1, 1, 3));
      vq.push_back(v(0, 3'b111, 0, 4, 0, 1, 1, 3));
      vq.push_back(v(0, 3'b111, 1, 1, 0, 0, 0, 3));
      vq.push_back(v(0, 3'b000, 0, 5, 1, 0, 1, 0));   // empty: fill with alarm
      vq.push_back(v(0, 3'b000, 0, 19, 1, 0, 1, 0));  // one short of timeout
      vq.push_back(v(0, 3'b000, 0, 1, 0, 1, 1, 0));   // timeout
      vq.push_back(v(0, 3'b000, 1, 1, 0, 0, 1, 0));   // back to IDLE, still empty
      vq.push_back(v(0, 3'b000, 0, 1, 1, 0, 1, 0));   // refill next edge
      vq.push_back(v(0, 3'b000, 0, 19, 1, 0, 1, 0));  // timer restarted from zero
      vq.push_back(v(0, 3'b000, 0, 1, 0, 1, 1, 0));
      vq.push_back(v(1, 3'b000, 0, 1, 0, 0, 0, 0));   // reset mid-FAULT

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].probes, vq[i].clr);
         tick(vq[i].cycles);
         expect_out($sformatf("row%0d", i), vq[i].valve, vq[i].erro, vq[i].alarme,
                    vq[i].nivel);
      end

      // Full and timeout evaluated on the same edge: full wins
      drive(1'b0, 3'b001, 1'b0);
      tick(5);
      expect_out("sim idle", 0, 0, 0, 1);
      tick(1);
      expect_out("sim fill", 1, 0, 0, 1);
      for (int k = 1; k <= 15; k++) begin
         tick(1);
         check($sformatf("sim open %0d", k), 32'(ValvulaEntrada), 32'd1);
      end
      drive(1'b0, 3'b111, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         check($sformatf("sim deb %0d", k), 32'({ValvulaEntrada, Erro, Nivel}), 32'b1001);
      end
      tick(1);
      expect_out("sim full", 0, 0, 0, 3);

      // Reset in the middle of a fill
      drive(1'b0, 3'b000, 1'b0);
      tick(5);
      expect_out("rst fill", 1, 0, 1, 0);
      drive(1'b1, 3'b000, 1'b0);
      tick(1);
      expect_out("rst edge", 0, 0, 0, 0);
      drive(1'b0, 3'b000, 1'b0);
      tick(4);
      expect_out("rst init", 0, 0, 0, 0);
      tick(1);
      expect_out("rst idle", 0, 0, 1, 0);
      tick(1);
      expect_out("rst refill", 1, 0, 1, 0);

      // Randomized run: mostly valid levels, occasional bad patterns, glitches and resets
      pattern     = 3'b111;
      gmask       = 3'b000;
      glitch_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 9))
               0, 1:    pattern = 3'b000;
               2, 3:    pattern = 3'b001;
               4, 5:    pattern = 3'b011;
               6, 7:    pattern = 3'b111;
               default: pattern = 3'($urandom_range(0, 7));
            endcase
         end
         if (glitch_left == 0 && $urandom_range(0, 19) == 0) begin
            gmask       = 3'b001 << $urandom_range(0, 2);
            glitch_left = int'($urandom_range(1, 5));
         end
         drive(($urandom_range(0, 399) == 0), (glitch_left > 0) ? (pattern ^ gmask) : pattern,
               ($urandom_range(0, 5) == 0));
         if (glitch_left > 0) glitch_left--;
         tick(1);
      end

      drive(1'b0, 3'b111, 1'b0);
      tick(2);
      model_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
